// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter/sequencer sharing one fixed-latency multiplier between two clients
//   clk_i, rst_ni                    clock, async active-low reset
//   reqN_valid_i/ready_o/a_i/b_i     operand request from client N (combinational grant on ready)
//   resN_valid_o/ready_i/p_o         one-entry product holding register for client N
//   mul_a_o, mul_b_o, mul_valid_o    registered operands to the multiplier
//   mul_p_i                          multiplier product, valid LAT edges after issue
module mul_arbiter #(
    parameter int WIDTH = 11,
    parameter int LAT   = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic [WIDTH-1:0]   req0_a_i,
    input  logic [WIDTH-1:0]   req0_b_i,
    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic [WIDTH-1:0]   req1_a_i,
    input  logic [WIDTH-1:0]   req1_b_i,
    output logic               res0_valid_o,
    input  logic               res0_ready_i,
    output logic [2*WIDTH-1:0] res0_p_o,
    output logic               res1_valid_o,
    input  logic               res1_ready_i,
    output logic [2*WIDTH-1:0] res1_p_o,
    output logic [WIDTH-1:0]   mul_a_o,
    output logic [WIDTH-1:0]   mul_b_o,
    output logic               mul_valid_o,
    input  logic [2*WIDTH-1:0] mul_p_i
);
    logic [1:0]         busy_q, busy_d, res_v_q, res_v_d;
    logic [1:0]         elig, gnt, pop, arrive;
    logic               rr_q, rr_d, mul_valid_q;
    logic [LAT-1:0]     tag_v_q, tag_v_d, tag_id_q, tag_id_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0] res0_p_q, res0_p_d, res1_p_q, res1_p_d;

    always_comb begin
        elig     = {req1_valid_i, req0_valid_i} & ~busy_q;
        // rr_q holds the id granted last; a tie goes to the other client
        gnt[0]   = elig[0] & (!elig[1] | rr_q);
        gnt[1]   = elig[1] & (!elig[0] | !rr_q);
        pop      = res_v_q & {res1_ready_i, res0_ready_i};
        arrive   = tag_v_q[LAT-1] ? (tag_id_q[LAT-1] ? 2'b10 : 2'b01) : 2'b00;
        busy_d   = (busy_q | gnt) & ~pop;
        res_v_d  = arrive | (res_v_q & ~pop);
        res0_p_d = arrive[0] ? mul_p_i : res0_p_q;
        res1_p_d = arrive[1] ? mul_p_i : res1_p_q;
        rr_d     = gnt[1] ? 1'b1 : gnt[0] ? 1'b0 : rr_q;
        mul_a_d  = gnt[1] ? req1_a_i : gnt[0] ? req0_a_i : mul_a_q;
        mul_b_d  = gnt[1] ? req1_b_i : gnt[0] ? req0_b_i : mul_b_q;
        // stage 0 takes the new tag; the top bit falls off as stage LAT is consumed
        tag_v_d  = LAT'({tag_v_q, |gnt});
        tag_id_d = LAT'({tag_id_q, gnt[1]});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q      <= '0;
            res_v_q     <= '0;
            rr_q        <= 1'b1;
            mul_valid_q <= 1'b0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res0_p_q    <= '0;
            res1_p_q    <= '0;
        end else begin
            busy_q      <= busy_d;
            res_v_q     <= res_v_d;
            rr_q        <= rr_d;
            mul_valid_q <= |gnt;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            res0_p_q    <= res0_p_d;
            res1_p_q    <= res1_p_d;
        end
    end

    assign req0_ready_o = gnt[0];
    assign req1_ready_o = gnt[1];
    assign res0_valid_o = res_v_q[0];
    assign res1_valid_o = res_v_q[1];
    assign res0_p_o     = res0_p_q;
    assign res1_p_o     = res1_p_q;
    assign mul_a_o      = mul_a_q;
    assign mul_b_o      = mul_b_q;
    assign mul_valid_o  = mul_valid_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: scoreboard model plus directed checks for mul_arbiter
module tb_mul_arbiter;
    localparam int W = 11;
    localparam int L = 2;

    logic clk = 0, rst_n = 0;
    logic req0_valid = 0, req1_valid = 0, res0_ready = 0, res1_ready = 0;
    logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic req0_ready, req1_ready, res0_valid, res1_valid, mul_valid;
    logic [2*W-1:0] res0_p, res1_p, mul_p;
    logic [W-1:0] mul_a, mul_b;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mul_arbiter #(.WIDTH(W), .LAT(L)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_a_i(req0_a), .req0_b_i(req0_b),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_a_i(req1_a), .req1_b_i(req1_b),
        .res0_valid_o(res0_valid), .res0_ready_i(res0_ready), .res0_p_o(res0_p),
        .res1_valid_o(res1_valid), .res1_ready_i(res1_ready), .res1_p_o(res1_p),
        .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_valid_o(mul_valid), .mul_p_i(mul_p)
    );

    function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] r;
        r = $signed(a) * $signed(b);
        return r;
    endfunction

    // multiplier stand-in: one register stage gives the product at the second edge after issue
    always @(posedge clk) mul_p <= smul(mul_a, mul_b);

    task automatic cmp(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    typedef struct { int id; logic [2*W-1:0] p; int due; } op_t;
    op_t q[$];
    int cyc = 0;
    int m_last = 1;
    bit m_busy[2] = '{0, 0};
    bit m_hv[2] = '{0, 0};
    logic [2*W-1:0] m_hp[2] = '{0, 0};
    bit m_mv = 0;
    logic [W-1:0] m_ma = 0, m_mb = 0;

    function automatic int pick();
        bit e0, e1;
        e0 = req0_valid && !m_busy[0];
        e1 = req1_valid && !m_busy[1];
        if (e0 && e1) return (m_last == 0) ? 1 : 0;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cyc = 0; m_last = 1; m_mv = 0; m_ma = 0; m_mb = 0;
            for (int i = 0; i < 2; i++) begin m_busy[i] = 0; m_hv[i] = 0; m_hp[i] = 0; end
        end else begin
            int g;
            g = pick();
            cyc++;
            if (m_hv[0] && res0_ready) begin m_hv[0] = 0; m_busy[0] = 0; end
            if (m_hv[1] && res1_ready) begin m_hv[1] = 0; m_busy[1] = 0; end
            while (q.size() > 0 && q[0].due == cyc) begin
                m_hv[q[0].id] = 1;
                m_hp[q[0].id] = q[0].p;
                void'(q.pop_front());
            end
            m_mv = (g >= 0);
            if (g >= 0) begin
                m_ma = g ? req1_a : req0_a;
                m_mb = g ? req1_b : req0_b;
                q.push_back('{g, smul(m_ma, m_mb), cyc + L});
                m_busy[g] = 1;
                m_last = g;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        g = pick();
        cmp("req0_ready", req0_ready, g == 0);
        cmp("req1_ready", req1_ready, g == 1);
        cmp("res0_valid", res0_valid, m_hv[0]);
        cmp("res1_valid", res1_valid, m_hv[1]);
        cmp("res0_p", res0_p, m_hp[0]);
        cmp("res1_p", res1_p, m_hp[1]);
        cmp("mul_valid", mul_valid, m_mv);
        cmp("mul_a", mul_a, m_ma);
        cmp("mul_b", mul_b, m_mb);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] r0, r1;
    int cnt1, n;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_res0_valid", res0_valid, 0);
        cmp("rst_res1_valid", res1_valid, 0);
        cmp("rst_res0_p", res0_p, 0);
        cmp("rst_mul_a", mul_a, 0);
        cmp("rst_mul_valid", mul_valid, 0);
        cmp("rst_req0_ready", req0_ready, 0);
        rst_n = 1;

        req0_valid = 1; req0_a = 3; req0_b = 5; res0_ready = 1;
        #1 cmp("single_gnt", req0_ready, 1);
        tick();
        req0_valid = 0;
        cmp("single_mulv", mul_valid, 1);
        cmp("single_mula", mul_a, 3);
        tick(); tick();
        cmp("single_valid", res0_valid, 1);
        cmp("single_p", res0_p, 22'h00F);
        tick();
        cmp("single_pop", res0_valid, 0);
        cmp("single_hold", res0_p, 22'h00F);

        res1_ready = 1; req0_valid = 1; req1_valid = 1; r0 = 0; r1 = 0;
        for (int i = 0; i < 16; i++) begin
            req0_a = W'(i); req0_b = W'(i + 1); req1_a = W'(i + 2); req1_b = 3;
            #1;
            r0[i] = req0_ready;
            r1[i] = req1_ready;
            tick();
        end
        cmp("fair_r0", r0, 16'h2222);
        cmp("fair_r1", r1, 16'h1111);
        req0_valid = 0; req1_valid = 0;
        repeat (6) tick();

        res0_ready = 0; req0_valid = 1; req0_a = 3; req0_b = 5;
        req1_valid = 1; req1_a = 1; req1_b = 2; cnt1 = 0;
        for (int i = 0; i < 12; i++) begin
            #1 cnt1 += int'(req1_ready);
            tick();
        end
        cmp("bp_req1_served", cnt1, 3);
        cmp("bp_valid", res0_valid, 1);
        cmp("bp_hold", res0_p, 22'h00F);
        cmp("bp_blocked", req0_ready, 0);
        req1_valid = 0;
        repeat (3) tick();
        res0_ready = 1;
        tick();
        cmp("bp_pop", res0_valid, 0);
        cmp("bp_pop_p", res0_p, 22'h00F);
        cmp("bp_regrant", req0_ready, 1);
        tick();
        req0_valid = 0;
        repeat (4) tick();

        req1_valid = 1; req1_a = 11'h7FD; req1_b = 11'h007; res1_ready = 1;
        tick();
        req1_valid = 0;
        n = 0;
        while (!res1_valid && n < 8) begin tick(); n++; end
        cmp("signed_arrive", res1_valid, 1);
        cmp("signed_p", res1_p, 22'h3FFFEB);
        repeat (3) tick();

        res0_ready = 0; req0_valid = 1; req0_a = 4; req0_b = 4;
        tick();
        req0_valid = 0;
        tick(); tick();
        cmp("same_held", res0_valid, 1);
        req1_valid = 1; req1_a = 6; req1_b = 7;
        #1 cmp("same_gnt1", req1_ready, 1);
        tick();
        req1_valid = 0;
        tick();
        res0_ready = 1;
        tick();
        cmp("same_pop0", res0_valid, 0);
        cmp("same_arr1", res1_valid, 1);
        cmp("same_p1", res1_p, 22'd42);
        cmp("same_p0", res0_p, 22'd16);
        repeat (4) tick();

        req0_valid = 1; req0_a = 9; req0_b = 9;
        tick();
        req0_valid = 0;
        tick();
        rst_n = 0;
        #1;
        cmp("mid_rst_valid", res0_valid, 0);
        cmp("mid_rst_mulv", mul_valid, 0);
        cmp("mid_rst_mula", mul_a, 0);
        cmp("mid_rst_p", res0_p, 0);
        tick();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            cmp("stale_ignored", res0_valid, 0);
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        cmp("rst_tie0", req0_ready, 1);
        cmp("rst_tie1", req1_ready, 0);
        tick();
        req0_valid = 0; req1_valid = 0;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
